// File: rtl/multi_rate_ticker.sv
// Multi-channel programmable tick generator: per-channel period, pause, restart,
// saturating speed-up, tick counter and at-minimum flag.
module multi_rate_ticker #(
    parameter int CHANNELS       = 2,
    parameter int WIDTH          = 32,
    parameter int DEFAULT_PERIOD = 50_000_000,
    parameter int MIN_PERIOD     = 1,
    parameter int COUNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CHANNELS*WIDTH-1:0]   period_in,
    input  logic [CHANNELS-1:0]         load,
    input  logic [CHANNELS-1:0]         run,
    input  logic [CHANNELS-1:0]         restart,
    input  logic [CHANNELS-1:0]         speed_up,
    input  logic [WIDTH-1:0]            step_in,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS*COUNT_W-1:0] tick_count,
    output logic [CHANNELS-1:0]         at_min
);

    localparam logic [WIDTH-1:0]   DEF_P   = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0]   MIN_P   = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);

    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] v);
        return (v < MIN_P) ? MIN_P : v;
    endfunction

    // Compare before subtracting so any step, including all-ones, cannot wrap.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] s);
        if (s >= p)
            return MIN_P;
        return clamp_period(p - s);
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0]   period_q;
        logic [WIDTH-1:0]   cnt_q;
        logic [WIDTH-1:0]   period_ld;
        logic [WIDTH-1:0]   period_nxt;
        logic               tick_q;
        logic [COUNT_W-1:0] count_q;

        assign period_ld  = clamp_period(period_in[g*WIDTH +: WIDTH]);
        assign period_nxt = speed_up[g] ? sat_dec(period_q, step_in) : period_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period_q <= DEF_P;
                cnt_q    <= DEF_P - ONE_W;
                tick_q   <= 1'b0;
                count_q  <= '0;
            end else if (load[g]) begin
                period_q <= period_ld;
                cnt_q    <= period_ld - ONE_W;
                tick_q   <= 1'b0;
                count_q  <= '0;
            end else begin
                period_q <= period_nxt;
                if (restart[g]) begin
                    cnt_q  <= period_nxt - ONE_W;
                    tick_q <= 1'b0;
                end else if (run[g] && cnt_q == '0) begin
                    cnt_q   <= period_nxt - ONE_W;
                    tick_q  <= 1'b1;
                    count_q <= count_q + ONE_C;
                end else if (run[g]) begin
                    cnt_q  <= cnt_q - ONE_W;
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= 1'b0;
                end
            end
        end

        assign tick[g]                          = tick_q;
        assign tick_count[g*COUNT_W +: COUNT_W] = count_q;
        assign at_min[g]                        = (period_q == MIN_P);
    end

endmodule

// File: tb/tb_multi_rate_ticker.sv
// Directed bench for multi_rate_ticker with DEFAULT_PERIOD=4, WIDTH=8, COUNT_W=8.
module tb_multi_rate_ticker;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [CH*W-1:0]   period_in;
    logic [CH-1:0]     load, run, restart, speed_up;
    logic [W-1:0]      step_in;
    logic [CH-1:0]     tick;
    logic [CH*CW-1:0]  tick_count;
    logic [CH-1:0]     at_min;

    int checks = 0;
    int errors = 0;

    multi_rate_ticker #(
        .CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(4), .MIN_PERIOD(1), .COUNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .period_in(period_in), .load(load),
        .run(run), .restart(restart), .speed_up(speed_up), .step_in(step_in),
        .tick(tick), .tick_count(tick_count), .at_min(at_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        period_in = '0;
        load      = '0;
        run       = '0;
        restart   = '0;
        speed_up  = '0;
        step_in   = '0;

        step();
        step();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_count", 32'(tick_count), 0);
        chk("rst_at_min", 32'(at_min), 0);

        // Free run from reset release: ticks on edges 4, 8, 12
        reset_n = 1'b1;
        run     = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("free_tick0", 32'(tick[0]), 32'(n % 4 == 0));
            chk("free_tick1", 32'(tick[1]), 32'(n % 4 == 0));
        end
        chk("free_count0", 32'(tick_count[7:0]), 3);

        // Pause channel 0 after edge 2 for 5 edges
        restart = 2'b11;
        step();
        restart = 2'b00;
        chk("restart_count0", 32'(tick_count[7:0]), 3);
        step();
        step();
        run = 2'b10;
        for (int n = 3; n <= 7; n++) begin
            step();
            chk("pause_tick0", 32'(tick[0]), 0);
            chk("pause_tick1", 32'(tick[1]), 32'(n == 4));
        end
        run = 2'b11;
        step();
        chk("resume_e1_tick0", 32'(tick[0]), 0);
        chk("resume_e1_tick1", 32'(tick[1]), 1);
        step();
        chk("resume_e2_tick0", 32'(tick[0]), 1);
        chk("resume_count0", 32'(tick_count[7:0]), 4);

        // Load period 0 clamps to 1
        period_in = '0;
        load      = 2'b01;
        step();
        load = 2'b00;
        chk("ld0_at_min", 32'(at_min[0]), 1);
        chk("ld0_count", 32'(tick_count[7:0]), 0);
        chk("ld0_tick", 32'(tick[0]), 0);
        for (int n = 1; n <= 3; n++) begin
            step();
            chk("p1_tick0", 32'(tick[0]), 1);
            chk("p1_count0", 32'(tick_count[7:0]), 32'(n));
        end

        // Speed-up from 10 by 3: 7, 4, 1, 1
        period_in[7:0] = 8'd10;
        load           = 2'b01;
        step();
        load = 2'b00;
        chk("ld10_at_min", 32'(at_min[0]), 0);
        step_in  = 8'd3;
        speed_up = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("spd_at_min", 32'(at_min[0]), 32'(k >= 3));
        end
        speed_up = 2'b00;
        chk("spd_ch1_at_min", 32'(at_min[1]), 0);
        restart = 2'b01;
        step();
        restart = 2'b00;
        chk("spd_restart_tick", 32'(tick[0]), 0);
        step();
        chk("spd_p1_tick", 32'(tick[0]), 1);

        // All-ones step must saturate, not wrap
        load = 2'b01;
        step();
        load     = 2'b00;
        step_in  = 8'hFF;
        speed_up = 2'b01;
        step();
        speed_up = 2'b00;
        chk("ff_at_min", 32'(at_min[0]), 1);

        // load + speed_up + restart together: load wins, period 6
        period_in[7:0] = 8'd6;
        step_in        = 8'd2;
        load           = 2'b01;
        speed_up       = 2'b01;
        restart        = 2'b01;
        step();
        load     = 2'b00;
        speed_up = 2'b00;
        restart  = 2'b00;
        chk("combo_at_min", 32'(at_min[0]), 0);
        chk("combo_count", 32'(tick_count[7:0]), 0);
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("combo_tick0", 32'(tick[0]), 32'(n == 6 || n == 12));
        end

        // restart + speed_up together: 8 - 2 = 6 applies immediately
        period_in[7:0] = 8'd8;
        load           = 2'b01;
        step();
        load     = 2'b00;
        restart  = 2'b01;
        speed_up = 2'b01;
        step();
        restart  = 2'b00;
        speed_up = 2'b00;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("rs_spd_tick0", 32'(tick[0]), 32'(n == 6 || n == 12));
        end

        // Asynchronous reset right after a tick on period 5
        period_in[7:0] = 8'd5;
        load           = 2'b01;
        step();
        load = 2'b00;
        for (int n = 1; n <= 5; n++) step();
        chk("pre_rst_tick0", 32'(tick[0]), 1);
        chk("pre_rst_count0", 32'(tick_count[7:0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_tick", 32'(tick), 0);
        chk("async_count", 32'(tick_count), 0);
        chk("async_at_min", 32'(at_min), 0);
        step();
        chk("in_rst_tick", 32'(tick), 0);
        reset_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("post_rst_tick0", 32'(tick[0]), 32'(n == 4));
        end
        chk("post_rst_count0", 32'(tick_count[7:0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_rate_ticker.md
Name: multi_rate_ticker

Overview:
- Parametrised, multi-channel successor to the single-channel tick divider used by the game top level.
- Each channel produces a one-cycle tick every programmable number of clocks. Channel examples: seconds timer, game-step clock.
- Adds features the old divider lacks: per-channel pause, restart and runtime period load, a saturating "speed-up" step so game pace rises with snake length, a tick counter, and an at-minimum flag.
- Sits between the system clock and the FSM, timer and splash logic.

Parameters:
- CHANNELS, 2, number of independent tick channels.
- WIDTH, 32, width of period, counter and step values.
- DEFAULT_PERIOD, 50_000_000, period loaded into every channel at reset. Must be ≥ MIN_PERIOD.
- MIN_PERIOD, 1, floor for any period value. Must be ≥ 1.
- COUNT_W, 16, width of each per-channel tick counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- period_in  input  CHANNELS*WIDTH  new period per channel; slice i = [i*WIDTH +: WIDTH].
- load  input  CHANNELS  per-channel strobe: latch period_in slice.
- run  input  CHANNELS  per-channel enable; low = paused.
- restart  input  CHANNELS  per-channel strobe: reload counter from current period.
- speed_up  input  CHANNELS  per-channel strobe: reduce period by step_in.
- step_in  input  WIDTH  shared decrement amount for speed_up.
- tick  output  CHANNELS  registered one-cycle tick per channel.
- tick_count  output  CHANNELS*COUNT_W  ticks issued since last load or reset, per channel.
- at_min  output  CHANNELS  high while the channel's period equals MIN_PERIOD.

Behaviour:
- Per-channel registers: period_q, cnt, tick, tick_count. Channels are fully independent.
- Reset (asynchronous, reset_n low):
  - period_q = DEFAULT_PERIOD, cnt = DEFAULT_PERIOD-1.
  - tick = 0, tick_count = 0, at_min = (DEFAULT_PERIOD == MIN_PERIOD).
  - Reset mid-count discards all progress. tick is never high during reset.
- Clamp function: clamp(v) = MIN_PERIOD if v < MIN_PERIOD, else v.
- Per-edge priority, highest first:
  1. load[i]:
     - period_q <= clamp(period_in slice), cnt <= clamp(period_in slice)-1.
     - tick <= 0, tick_count <= 0.
     - speed_up and restart are ignored that cycle.
  2. restart[i]:
     - cnt <= p-1, tick <= 0, where p = period_q after any same-cycle speed_up.
     - tick_count unchanged.
  3. run[i] and cnt == 0:
     - tick <= 1, cnt <= p-1, tick_count <= tick_count+1 (wraps modulo 2^COUNT_W).
  4. run[i] and cnt != 0: cnt <= cnt-1, tick <= 0.
  5. run[i] low: cnt holds, tick <= 0.
- Timing: with run held high and no strobes, tick is high for exactly 1 cycle out of every period_q cycles. The first tick after reset release or restart occurs on the period_q-th rising edge.
- speed_up[i] without load:
  - period_q <= max(period_q - step_in, MIN_PERIOD). Compare before subtracting; no underflow for any step_in, including all-ones.
  - cnt is not modified unless restart occurs in the same cycle. A running count finishes under the old value, and the new period applies from the next reload.
  - step_in = 0 is a no-op.
- Period of 1: tick is high every cycle while run is high.
- at_min is combinational from period_q (period_q == MIN_PERIOD).
- Strobes are level-sampled each edge. A strobe held for N cycles acts N times; for speed_up this means N decrements.

Test Plan:
- DEFAULT_PERIOD=4, run=2'b11 from reset release, no strobes:
  - tick[0] high on edges 4, 8, 12, each for 1 cycle; never high during reset.
  - tick_count[0] = 3 after edge 12.
- Channel 0 running with period 4, run[0] dropped for 5 cycles after edge 2:
  - no ticks while paused;
  - next tick 2 edges after run returns;
  - channel 1 unaffected.
- load[0] with period_in=0 (MIN_PERIOD=1) → period_q=1, at_min=1, tick every cycle, tick_count restarts from 0.
- period_q=10, step_in=3, speed_up pulsed 4 times → period_q = 7, 4, 1, 1; at_min rises after the 3rd pulse. With step_in=all-ones from period_q=10 → period_q=1 with no wrap.
- Same cycle load[0] + speed_up[0] + restart[0], period_in=6 → period_q=6 and cnt=5; speed_up ignored.
- Same cycle restart[0] + speed_up[0], period_q=8, step_in=2 → period_q=6, next tick 6 edges later.
- reset_n asserted mid-count on period 5 → all outputs return to reset values immediately (asynchronous); counting restarts cleanly after release.
